// File: rtl/ibex_mem_port_arbiter.sv
// ibex_mem_port_arbiter
// Shares one single-ported RAM between the Ibex instruction and data ports.
// Data wins by default. An instruction request that has watched MaxDataStreak
// data grants go by takes the next slot. A request that has been forwarded but
// not granted stays locked until it is granted or its owner withdraws it.
// Read data comes back exactly one cycle after the grant and is steered to the
// requester that was granted.
module ibex_mem_port_arbiter #(
    parameter int AddrWidth     = 15,
    parameter int DataWidth     = 32,
    parameter int MaxDataStreak = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 instr_req_i,
    output logic                 instr_gnt_o,
    input  logic [AddrWidth-1:0] instr_addr_i,
    input  logic [DataWidth-1:0] instr_wdata_i,
    input  logic [DataWidth-1:0] instr_strb_i,
    input  logic                 instr_we_i,
    output logic                 instr_rvalid_o,
    output logic [DataWidth-1:0] instr_rdata_o,

    input  logic                 data_req_i,
    output logic                 data_gnt_o,
    input  logic [AddrWidth-1:0] data_addr_i,
    input  logic [DataWidth-1:0] data_wdata_i,
    input  logic [DataWidth-1:0] data_strb_i,
    input  logic                 data_we_i,
    output logic                 data_rvalid_o,
    output logic [DataWidth-1:0] data_rdata_o,

    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic [DataWidth-1:0] mem_strb_o,
    output logic                 mem_we_o,
    input  logic [DataWidth-1:0] mem_rdata_i
);

    // Port index: 0 = instruction side, 1 = data side.
    localparam logic       SEL_INSTR  = 1'b0;
    localparam logic       SEL_DATA   = 1'b1;
    localparam logic [7:0] STREAK_MAX = 8'(MaxDataStreak);

    typedef struct packed {
        logic                 req;
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] wdata;
        logic [DataWidth-1:0] strb;
        logic                 we;
    } port_req_t;

    port_req_t [1:0] port;
    port_req_t       fwd;

    logic       lock_q;
    logic       lock_owner_q;
    logic [7:0] streak_q;
    logic       rsp_valid_q;
    logic       rsp_owner_q;

    logic       lock_hold;
    logic       sel;
    logic       req_fwd;
    logic       gnt;

    assign port[SEL_INSTR] = {instr_req_i, instr_addr_i, instr_wdata_i, instr_strb_i, instr_we_i};
    assign port[SEL_DATA]  = {data_req_i,  data_addr_i,  data_wdata_i,  data_strb_i,  data_we_i};

    // Pick a requester. The lock only holds while its owner still requests,
    // so a withdrawn request hands the port over in the same cycle.
    always_comb begin
        lock_hold = lock_q & port[lock_owner_q].req;
        sel       = SEL_INSTR;
        if (lock_hold) begin
            sel = lock_owner_q;
        end else if (instr_req_i && data_req_i) begin
            sel = (streak_q == STREAK_MAX) ? SEL_INSTR : SEL_DATA;
        end else begin
            sel = data_req_i;
        end
    end

    // Forward the selected request; everything is zero when nothing is forwarded
    // or while reset is asserted.
    always_comb begin
        req_fwd = port[sel].req & ~rst_i;
        fwd     = req_fwd ? port[sel] : '0;
        gnt     = mem_gnt_i & req_fwd;
    end

    assign mem_req_o   = fwd.req;
    assign mem_addr_o  = fwd.addr;
    assign mem_wdata_o = fwd.wdata;
    assign mem_strb_o  = fwd.strb;
    assign mem_we_o    = fwd.we;

    assign instr_gnt_o = gnt & (sel == SEL_INSTR);
    assign data_gnt_o  = gnt & (sel == SEL_DATA);

    // Steer the one-cycle-late RAM read data to the side granted last cycle.
    assign instr_rvalid_o = rsp_valid_q & (rsp_owner_q == SEL_INSTR);
    assign data_rvalid_o  = rsp_valid_q & (rsp_owner_q == SEL_DATA);
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : '0;

    // Lock, anti-starvation streak and response tracking.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
            streak_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_owner_q  <= 1'b0;
        end else begin
            if (req_fwd && !mem_gnt_i) begin
                lock_q       <= 1'b1;
                lock_owner_q <= sel;
            end else begin
                lock_q <= 1'b0;
            end

            if (gnt && (sel == SEL_DATA) && instr_req_i) begin
                streak_q <= (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 8'd1;
            end else if ((gnt && (sel == SEL_INSTR)) || !instr_req_i) begin
                streak_q <= '0;
            end

            rsp_valid_q <= gnt;
            rsp_owner_q <= sel;
        end
    end

endmodule

// File: tb/tb_ibex_mem_port_arbiter.sv
// Randomized bench for ibex_mem_port_arbiter. The driver checks the
// combinational request path against a reference model every cycle and pushes
// the expected read response into a queue. The monitor pops that queue and
// checks what the DUT returns.
module tb_ibex_mem_port_arbiter;

    localparam int AW  = 15;
    localparam int DW  = 32;
    localparam int MAX = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          instr_req_i = 0, instr_we_i = 0;
    logic [AW-1:0] instr_addr_i = '0;
    logic [DW-1:0] instr_wdata_i = '0, instr_strb_i = '0;
    logic          data_req_i = 0, data_we_i = 0;
    logic [AW-1:0] data_addr_i = '0;
    logic [DW-1:0] data_wdata_i = '0, data_strb_i = '0;
    logic          mem_gnt_i = 0;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o;
    logic          mem_req_o, mem_we_o;
    logic [DW-1:0] instr_rdata_o, data_rdata_o, mem_wdata_o, mem_strb_o;
    logic [AW-1:0] mem_addr_o;

    ibex_mem_port_arbiter #(.AddrWidth(AW), .DataWidth(DW), .MaxDataStreak(MAX)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
        .instr_wdata_i(instr_wdata_i), .instr_strb_i(instr_strb_i), .instr_we_i(instr_we_i),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_strb_i(data_strb_i), .data_we_i(data_we_i),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o), .mem_we_o(mem_we_o),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        bit          owner;   // 0 = instr, 1 = data
        logic [31:0] rdata;
        int          due;
    } rsp_t;
    rsp_t rsp_q[$];

    int errs = 0;
    int checks = 0;

    // Reference model state: who was offered the port and left waiting, and
    // how many data grants an instr request has sat through.
    int          m_pend = -1;
    int          m_wins = 0;
    logic [31:0] nxt_rdata = '0;
    bit          use_ovr = 0;
    logic [31:0] ovr_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus. Inputs change just after the rising edge; the
    // request path is checked on the falling edge.
    task automatic step(input bit ir, input bit dr, input bit g,
                        input logic [AW-1:0] ia, input logic [DW-1:0] iwd,
                        input logic [DW-1:0] ist, input bit iwe,
                        input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                        input logic [DW-1:0] dst, input bit dwe);
        bit [1:0] rq;
        int s;
        bit act, gg;
        @(posedge clk_i); #1;
        mem_rdata_i = nxt_rdata;
        instr_req_i = ir; instr_addr_i = ia; instr_wdata_i = iwd; instr_strb_i = ist; instr_we_i = iwe;
        data_req_i  = dr; data_addr_i  = da; data_wdata_i  = dwd; data_strb_i  = dst; data_we_i  = dwe;
        mem_gnt_i   = g;
        @(negedge clk_i);
        rq = {dr, ir};
        if (m_pend >= 0 && rq[m_pend]) s = m_pend;
        else if (ir && dr)             s = (m_wins >= MAX) ? 0 : 1;
        else                           s = dr ? 1 : 0;
        act = rq[s];
        gg  = act && g;
        chk("mem_req",   64'(mem_req_o),   64'(act));
        chk("instr_gnt", 64'(instr_gnt_o), 64'(gg && s == 0));
        chk("data_gnt",  64'(data_gnt_o),  64'(gg && s == 1));
        chk("mem_addr",  64'(mem_addr_o),  act ? 64'(s ? da  : ia)  : 64'd0);
        chk("mem_wdata", 64'(mem_wdata_o), act ? 64'(s ? dwd : iwd) : 64'd0);
        chk("mem_strb",  64'(mem_strb_o),  act ? 64'(s ? dst : ist) : 64'd0);
        chk("mem_we",    64'(mem_we_o),    act ? 64'(s ? dwe : iwe) : 64'd0);
        nxt_rdata = use_ovr ? ovr_rdata : $urandom;
        use_ovr   = 0;
        if (gg) rsp_q.push_back('{owner: s[0], rdata: nxt_rdata, due: cyc + 1});
        m_pend = (act && !g) ? s : -1;
        if (gg && s == 1 && ir)          m_wins = (m_wins + 1 > MAX) ? MAX : m_wins + 1;
        else if ((gg && s == 0) || !ir)  m_wins = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, '0, 0, '0, '0, '0, 0);
    endtask

    // Reset asserted just after a rising edge with both sides requesting;
    // nothing may be forwarded or granted while it is held.
    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_i = 1; instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1;
        @(negedge clk_i);
        chk("rst_mem_req",  64'(mem_req_o), 0);
        chk("rst_gnts",     64'({instr_gnt_o, data_gnt_o}), 0);
        chk("rst_mem_addr", 64'(mem_addr_o), 0);
        m_pend = -1; m_wins = 0;
        @(posedge clk_i); #1;
        rst_i = 0; instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0;
    endtask

    // Monitor: a response is expected exactly on its due cycle, otherwise
    // both rvalids must be low. Reset drops anything outstanding.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                rsp_q.delete();
                chk("rst_rvalid", 64'({instr_rvalid_o, data_rvalid_o}), 0);
            end else if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                e = rsp_q.pop_front();
                chk("rvalid", 64'({instr_rvalid_o, data_rvalid_o}), e.owner ? 64'b01 : 64'b10);
                chk("instr_rdata", 64'(instr_rdata_o), e.owner ? 64'd0 : 64'(e.rdata));
                chk("data_rdata",  64'(data_rdata_o),  e.owner ? 64'(e.rdata) : 64'd0);
            end else begin
                chk("idle_rvalid", 64'({instr_rvalid_o, data_rvalid_o}), 0);
            end
        end
    end

    initial begin
        // Reset state.
        @(negedge clk_i);
        chk("reset_outputs", 64'({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o}), 0);
        chk("reset_data", 64'(mem_addr_o | mem_wdata_o | mem_strb_o | instr_rdata_o | data_rdata_o), 0);
        @(posedge clk_i); #1; rst_i = 0;

        // Single instruction read returning DEADBEEF.
        use_ovr = 1; ovr_rdata = 32'hDEADBEEF;
        step(1, 0, 1, 15'h0010, '0, '0, 0, '0, '0, '0, 0);
        chk("t1_instr_gnt", 64'(instr_gnt_o), 1);
        step(0, 0, 0, '0, '0, '0, 0, '0, '0, '0, 0);
        chk("t1_rsp", 64'({instr_rvalid_o, data_rvalid_o, instr_rdata_o}), {2'b10, 32'hDEADBEEF});

        // Both sides requesting continuously: D,D,D,D,I repeating.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 1, 15'(i), $urandom, $urandom, 0, 15'(100 + i), $urandom, $urandom, 0);
            chk("t2_order", 64'({instr_gnt_o, data_gnt_o}), (i % 5 == 4) ? 64'b10 : 64'b01);
        end

        // Instr stalled three cycles, data arrives in cycle 1 and waits.
        do_reset();
        step(1, 0, 0, 15'h0123, '0, '0, 0, 15'h0456, '0, '0, 0);
        step(1, 1, 0, 15'h0123, '0, '0, 0, 15'h0456, '0, '0, 0);
        chk("t3_addr_held", 64'(mem_addr_o), 64'h0123);
        step(1, 1, 0, 15'h0123, '0, '0, 0, 15'h0456, '0, '0, 0);
        step(1, 1, 1, 15'h0123, '0, '0, 0, 15'h0456, '0, '0, 0);
        chk("t3_instr_first", 64'({instr_gnt_o, data_gnt_o}), 64'b10);
        step(0, 1, 1, '0, '0, '0, 0, 15'h0456, '0, '0, 0);
        chk("t3_data_next", 64'({instr_gnt_o, data_gnt_o}), 64'b01);

        // Data write at the top of the address space.
        step(0, 1, 1, '0, '0, '0, 0, 15'h7FFF, 32'h12345678, 32'hFFFF0000, 1);
        chk("t4_fields", {mem_we_o, mem_addr_o, mem_wdata_o}, {1'b1, 15'h7FFF, 32'h12345678});
        chk("t4_strb", 64'(mem_strb_o), 64'hFFFF0000);
        chk("t4_gnt", 64'(data_gnt_o), 1);
        step(0, 0, 0, '0, '0, '0, 0, '0, '0, '0, 0);
        chk("t4_rvalid", 64'(data_rvalid_o), 1);

        // Reset in the cycle after a grant drops the response.
        step(1, 0, 1, 15'h0042, '0, '0, 0, '0, '0, '0, 0);
        do_reset();

        // Locked data owner withdraws; instr takes over the same cycle.
        step(1, 1, 0, 15'h0AAA, '0, '0, 0, 15'h0BBB, '0, '0, 0);
        chk("t6_data_locked", 64'(mem_addr_o), 64'h0BBB);
        step(1, 0, 0, 15'h0AAA, '0, '0, 0, 15'h0BBB, '0, '0, 0);
        chk("t6_instr_takes", 64'({mem_req_o, mem_addr_o}), {1'b1, 15'h0AAA});
        step(1, 1, 1, 15'h0AAA, '0, '0, 0, 15'h0BBB, '0, '0, 0);
        chk("t6_instr_kept", 64'(instr_gnt_o), 1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
                 15'($urandom), $urandom, $urandom, 1'($urandom),
                 15'($urandom), $urandom, $urandom, 1'($urandom));
            if (i == 300) do_reset();
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
